nx1_gram_arb: RTL and testbench
===============================

# nx1_gram_arb

Single-port graphic VRAM arbiter for the X1 core. It shares one three-plane GRAM (B/R/G, 16 KiB per plane, common address bus) between the Z80 I/O-space requester and the CRTC display fetcher. It applies DAM (simultaneous write) plane masking from the mode block's DAM flag, and stalls the CPU through a wait output. It sits between the bus decode/mode logic and the external GRAM port.

## Interface
- MEM_LAT, 1: GRAM read latency in clocks, from address-valid to data-valid; legal 1..3.
- C_CLK  in  1  system clock
- I_RESET  in  1  asynchronous, active-high reset
- I_CPU_REQ  in  1  CPU GRAM access request, level; held until O_CPU_ACK
- I_CPU_WE  in  1  1 = write, 0 = read; sampled at grant
- I_CPU_A  in  16  CPU I/O address; sampled at grant
- I_CPU_D  in  8  write data; sampled at grant
- I_DAM  in  1  DAM mode flag from the mode block; sampled at grant
- O_CPU_Q  out  8  read data; valid in the cycle O_CPU_ACK is high
- O_CPU_ACK  out  1  one-cycle completion pulse
- O_CPU_WAIT  out  1  combinational: I_CPU_REQ & ~O_CPU_ACK & ~(state==IDLE & grant-to-CPU)
- I_DSP_REQ  in  1  display fetch request, level
- I_DSP_A  in  14  display fetch address
- O_DSP_Q  out  24  {G,R,B} plane data
- O_DSP_ACK  out  1  one-cycle completion pulse
- O_MEM_A  out  14  GRAM address
- O_MEM_WE  out  3  per-plane write enable {G,R,B}
- O_MEM_D  out  8  GRAM write data, common to all planes
- I_MEM_Q  in  24  GRAM read data {G,R,B}

## Operation
- FSM states: IDLE, ACC_DSP, ACC_CPU. Counter lat_cnt (2 bit) times the MEM_LAT wait.
- IDLE grant rule, evaluated at each edge:
  - Only one request pending: grant it.
  - Both pending: grant display, unless the last grant was display; then grant CPU (alternation).
  - last_dsp flag records the last granted requester.
- CPU plane decode from A[15:14]: 01=B, 10=R, 11=G, 00=none.
- CPU write, I_DAM=0: O_MEM_WE = the one-hot decoded plane.
- CPU write, I_DAM=1, by A[15:14]: 00→3'b111; 01→{G,R}=3'b110; 10→{G,B}=3'b101; 11→{R,B}=3'b011.
- CPU read ignores I_DAM. A[15:14]=00 returns 8'hFF. Other codes return the selected plane byte of I_MEM_Q.
- Non-DAM write with A[15:14]=00: O_MEM_WE=0, still acknowledged normally.
- O_MEM_A = CPU A[13:0] or I_DSP_A, latched at grant and held through the access.
- O_MEM_D = latched I_CPU_D.
- Display read: O_DSP_Q is I_MEM_Q captured unchanged.

## Timing
- Reset values: state IDLE, lat_cnt 0, last_dsp 0, O_MEM_A 0, O_MEM_WE 0, O_MEM_D 0, O_CPU_Q 8'hFF, O_DSP_Q 0, both ACKs 0.
- Grant at edge k, where the request was high before edge k. O_MEM_A, O_MEM_D and O_MEM_WE are registered at edge k and valid in cycle k.
- Writes assert O_MEM_WE for exactly one cycle (cycle k). O_MEM_WE returns to 0 at edge k+1.
- ACK and read data are registered at edge k+MEM_LAT, capturing I_MEM_Q at that edge. The state returns to IDLE at the same edge. Writes use the same ACK timing.
- The next grant is no earlier than edge k+MEM_LAT+1. Each requester drops REQ in the ACK cycle, or keeps it high for a back-to-back access. Peak throughput is one access per MEM_LAT+1 clocks.
- Requests arriving during an access wait. No request is lost or reordered within a requester.
- I_RESET mid-access: the access is aborted, with no ACK and WE forced 0 immediately. The requester re-issues after reset.
- I_DAM changes during an access do not affect that access.

## Structure
- Shared package nx1_pkg holds:
  - plane codes (PL_NONE=2'b00, PL_B=2'b01, PL_R=2'b10, PL_G=2'b11);
  - FSM state encoding;
  - WE bit order constants (WE_B=0, WE_R=1, WE_G=2).
- Sub-module nx1_gram_plane_dec is purely combinational: {A[15:14], DAM, WE} → O_MEM_WE mask and read-select. It is reused by the text/attribute VRAM path.
- Arbiter FSM, latches and latency counter live in the top module.

## Test plan
- Reset, then idle: all outputs at reset values. MEM_LAT=1, single display REQ with A=14'h0123 and memory returning 24'hAABBCC → O_DSP_Q=24'hAABBCC with ACK 1 edge after grant.
- CPU write, DAM=0, A=16'h8005, D=8'h5A → O_MEM_A=14'h0005, O_MEM_WE=3'b010 for one cycle, ACK next edge, WAIT high until ACK.
- CPU write, DAM=1, A=16'h4010, D=8'h3C → O_MEM_WE=3'b110. Repeat with A=16'h0010 → 3'b111.
- Both REQ continuously high → grants alternate DSP, CPU, DSP, CPU. Each ACK is a single pulse, spaced MEM_LAT+1 clocks apart.
- CPU read A=16'hC020 with I_MEM_Q=24'h11_22_33 → O_CPU_Q=8'h11. Read A=16'h0020 → 8'hFF.
- MEM_LAT=3, I_RESET asserted in the cycle after grant → WE/ACK 0 at once. After release, the re-issued request completes normally.

Source files
------------

// File: rtl/nx1_pkg.sv
// Purpose : shared X1 GRAM constants: plane codes, WE bit order, arbiter state encoding.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: PL_* plane codes (from CPU A[15:14]), WE_* bit positions in the {G,R,B} buses,
//           arb_state_t, plane_byte() read-lane select helper.
package nx1_pkg;

    // Plane code carried in CPU address bits [15:14].
    localparam logic [1:0] PL_NONE = 2'b00;
    localparam logic [1:0] PL_B    = 2'b01;
    localparam logic [1:0] PL_R    = 2'b10;
    localparam logic [1:0] PL_G    = 2'b11;

    // Bit / byte-lane position of each plane in WE and data buses ({G,R,B}).
    localparam int WE_B = 0;
    localparam int WE_R = 1;
    localparam int WE_G = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_DSP = 2'd1,
        ACC_CPU = 2'd2
    } arb_state_t;

    // Pick one plane byte out of a {G,R,B} word; "no plane" reads as open bus.
    function automatic logic [7:0] plane_byte(input logic [23:0] q, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            PL_B:    b = q[8*WE_B +: 8];
            PL_R:    b = q[8*WE_R +: 8];
            PL_G:    b = q[8*WE_G +: 8];
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/nx1_gram_arb_if.sv
// Purpose : bundle of CPU, display and GRAM port signals around the GRAM arbiter.
// Latency : n/a (wiring only).
// Backpr. : CPU stalled by O_CPU_WAIT; both requesters hold REQ until their ACK pulse.
// Modports: slave  = arbiter view (I_* in, O_* out)
//           master = environment view (drives I_*, observes O_*)
interface nx1_gram_arb_if;

    logic        I_CPU_REQ;
    logic        I_CPU_WE;
    logic [15:0] I_CPU_A;
    logic [7:0]  I_CPU_D;
    logic        I_DAM;
    logic [7:0]  O_CPU_Q;
    logic        O_CPU_ACK;
    logic        O_CPU_WAIT;

    logic        I_DSP_REQ;
    logic [13:0] I_DSP_A;
    logic [23:0] O_DSP_Q;
    logic        O_DSP_ACK;

    logic [13:0] O_MEM_A;
    logic [2:0]  O_MEM_WE;
    logic [7:0]  O_MEM_D;
    logic [23:0] I_MEM_Q;

    modport slave (
        input  I_CPU_REQ, I_CPU_WE, I_CPU_A, I_CPU_D, I_DAM,
        output O_CPU_Q, O_CPU_ACK, O_CPU_WAIT,
        input  I_DSP_REQ, I_DSP_A,
        output O_DSP_Q, O_DSP_ACK,
        output O_MEM_A, O_MEM_WE, O_MEM_D,
        input  I_MEM_Q
    );

    modport master (
        output I_CPU_REQ, I_CPU_WE, I_CPU_A, I_CPU_D, I_DAM,
        input  O_CPU_Q, O_CPU_ACK, O_CPU_WAIT,
        output I_DSP_REQ, I_DSP_A,
        input  O_DSP_Q, O_DSP_ACK,
        input  O_MEM_A, O_MEM_WE, O_MEM_D,
        output I_MEM_Q
    );

endinterface

// File: rtl/nx1_gram_plane_dec.sv
// Purpose : GRAM plane decode: {A[15:14], DAM, WE} -> per-plane write mask and read lane select.
// Latency : combinational.
// Backpr. : none.
// Ports   : plane_i (A[15:14]), dam_i, we_i -> we_mask_o {G,R,B}, rd_sel_o (plane code).
module nx1_gram_plane_dec
    import nx1_pkg::*;
(
    input  logic [1:0] plane_i,
    input  logic       dam_i,
    input  logic       we_i,
    output logic [2:0] we_mask_o,
    output logic [1:0] rd_sel_o
);

    logic [2:0] onehot;

    always_comb begin
        onehot = 3'b000;
        case (plane_i)
            PL_B:    onehot[WE_B] = 1'b1;
            PL_R:    onehot[WE_R] = 1'b1;
            PL_G:    onehot[WE_G] = 1'b1;
            default: onehot = 3'b000;
        endcase
    end

    // DAM writes every plane except the addressed one; code 00 (no plane) thus hits all three.
    assign we_mask_o = !we_i ? 3'b000 : (dam_i ? ~onehot : onehot);

    // Reads ignore DAM; the plane code doubles as the lane select.
    assign rd_sel_o  = plane_i;

endmodule

// File: rtl/nx1_gram_arb.sv
// Purpose : single-port 3-plane GRAM arbiter between Z80 I/O requester and CRTC display fetch.
// Latency : grant one edge after REQ, ACK + read data MEM_LAT edges after grant; one access per MEM_LAT+1 clocks.
// Backpr. : CPU held by combinational O_CPU_WAIT; requests wait in IDLE, alternating when both pend.
// Ports   : C_CLK, I_RESET (async, active-high), bus (nx1_gram_arb_if.slave): CPU, display and GRAM port.
module nx1_gram_arb
    import nx1_pkg::*;
#(
    parameter int MEM_LAT = 1     // GRAM read latency, 1..3
) (
    input  logic          C_CLK,
    input  logic          I_RESET,
    nx1_gram_arb_if.slave bus
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    arb_state_t  state_q,    state_d;
    logic [1:0]  lat_cnt_q,  lat_cnt_d;
    logic        last_dsp_q, last_dsp_d;
    logic        cpu_we_q,   cpu_we_d;
    logic [1:0]  rd_sel_q,   rd_sel_d;
    logic [13:0] mem_a_q,    mem_a_d;
    logic [2:0]  mem_we_q,   mem_we_d;
    logic [7:0]  mem_d_q,    mem_d_d;
    logic [7:0]  cpu_q_q,    cpu_q_d;
    logic        cpu_ack_q,  cpu_ack_d;
    logic [23:0] dsp_q_q,    dsp_q_d;
    logic        dsp_ack_q,  dsp_ack_d;

    logic        grant_dsp;
    logic        grant_cpu;
    logic [2:0]  dec_we_mask;
    logic [1:0]  dec_rd_sel;

    nx1_gram_plane_dec u_plane_dec (
        .plane_i   (bus.I_CPU_A[15:14]),
        .dam_i     (bus.I_DAM),
        .we_i      (bus.I_CPU_WE),
        .we_mask_o (dec_we_mask),
        .rd_sel_o  (dec_rd_sel)
    );

    // Display wins a tie unless it had the previous grant.
    assign grant_dsp = (state_q == IDLE) && bus.I_DSP_REQ && (!bus.I_CPU_REQ || !last_dsp_q);
    assign grant_cpu = (state_q == IDLE) && bus.I_CPU_REQ && (!bus.I_DSP_REQ ||  last_dsp_q);

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        last_dsp_d = last_dsp_q;
        cpu_we_d   = cpu_we_q;
        rd_sel_d   = rd_sel_q;
        mem_a_d    = mem_a_q;
        mem_d_d    = mem_d_q;
        cpu_q_d    = cpu_q_q;
        dsp_q_d    = dsp_q_q;
        mem_we_d   = 3'b000;    // WE only ever lives in the grant cycle
        cpu_ack_d  = 1'b0;
        dsp_ack_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_dsp) begin
                    state_d    = ACC_DSP;
                    mem_a_d    = bus.I_DSP_A;
                    lat_cnt_d  = LAT_LOAD;
                    last_dsp_d = 1'b1;
                end else if (grant_cpu) begin
                    state_d    = ACC_CPU;
                    mem_a_d    = bus.I_CPU_A[13:0];
                    mem_d_d    = bus.I_CPU_D;
                    mem_we_d   = dec_we_mask;
                    rd_sel_d   = dec_rd_sel;
                    cpu_we_d   = bus.I_CPU_WE;
                    lat_cnt_d  = LAT_LOAD;
                    last_dsp_d = 1'b0;
                end
            end

            ACC_DSP: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d   = IDLE;
                    dsp_ack_d = 1'b1;
                    dsp_q_d   = bus.I_MEM_Q;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end

            ACC_CPU: begin
                if (lat_cnt_q == 2'd0) begin
                    state_d   = IDLE;
                    cpu_ack_d = 1'b1;
                    // Writes keep the last read value on O_CPU_Q.
                    if (!cpu_we_q) begin
                        cpu_q_d = plane_byte(bus.I_MEM_Q, rd_sel_q);
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Async reset aborts an in-flight access: WE and ACK drop immediately.
    always_ff @(posedge C_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 2'd0;
            last_dsp_q <= 1'b0;
            cpu_we_q   <= 1'b0;
            rd_sel_q   <= PL_NONE;
            mem_a_q    <= 14'd0;
            mem_we_q   <= 3'b000;
            mem_d_q    <= 8'h00;
            cpu_q_q    <= 8'hFF;
            cpu_ack_q  <= 1'b0;
            dsp_q_q    <= 24'd0;
            dsp_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            last_dsp_q <= last_dsp_d;
            cpu_we_q   <= cpu_we_d;
            rd_sel_q   <= rd_sel_d;
            mem_a_q    <= mem_a_d;
            mem_we_q   <= mem_we_d;
            mem_d_q    <= mem_d_d;
            cpu_q_q    <= cpu_q_d;
            cpu_ack_q  <= cpu_ack_d;
            dsp_q_q    <= dsp_q_d;
            dsp_ack_q  <= dsp_ack_d;
        end
    end

    assign bus.O_MEM_A    = mem_a_q;
    assign bus.O_MEM_WE   = mem_we_q;
    assign bus.O_MEM_D    = mem_d_q;
    assign bus.O_CPU_Q    = cpu_q_q;
    assign bus.O_CPU_ACK  = cpu_ack_q;
    assign bus.O_DSP_Q    = dsp_q_q;
    assign bus.O_DSP_ACK  = dsp_ack_q;
    // No wait in the cycle the CPU is about to be granted, nor in its ACK cycle.
    assign bus.O_CPU_WAIT = bus.I_CPU_REQ && !cpu_ack_q && !grant_cpu;

endmodule

// File: tb/tb_nx1_gram_arb.sv
// Purpose : self-checking bench for nx1_gram_arb at MEM_LAT=1 (dut1) and MEM_LAT=3 (dut3).
// Latency : n/a.
// Backpr. : n/a.
module tb_nx1_gram_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst3;

    nx1_gram_arb_if if1 ();
    nx1_gram_arb_if if3 ();

    nx1_gram_arb #(.MEM_LAT(1)) dut1 (.C_CLK(clk), .I_RESET(rst1), .bus(if1));
    nx1_gram_arb #(.MEM_LAT(3)) dut3 (.C_CLK(clk), .I_RESET(rst3), .bus(if3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no ACK expected ACK within cycle budget", name);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
        logic        dam;
        logic [23:0] mq;
        logic [2:0]  exp_we;
        logic [7:0]  exp_q;
    } vec_t;

    typedef struct {
        logic        is_cpu;
        logic        rd;
        logic [7:0]  q;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    // One CPU access on dut1; entered and left at #1 after a clock edge.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n;
        bit   done;
        if1.I_CPU_REQ = 1'b1;
        if1.I_CPU_WE  = v.we;
        if1.I_CPU_A   = v.a;
        if1.I_CPU_D   = v.d;
        if1.I_DAM     = v.dam;
        e.is_cpu = 1'b1;
        e.rd     = !v.we;
        e.q      = v.exp_q;
        sb.push_back(e);
        #1;
        chk("wait_pre_grant", 32'(if1.O_CPU_WAIT), 32'd0);
        @(posedge clk); #1;
        chk("grant_we",   32'(if1.O_MEM_WE), 32'(v.exp_we));
        chk("grant_addr", 32'(if1.O_MEM_A),  32'(v.a[13:0]));
        chk("grant_ack_low", 32'(if1.O_CPU_ACK), 32'd0);
        if (v.we) chk("grant_data", 32'(if1.O_MEM_D), 32'(v.d));
        chk("wait_in_access", 32'(if1.O_CPU_WAIT), 32'd1);
        // Inputs are only sampled at grant; scramble them for the rest of the access.
        if1.I_DAM    = ~v.dam;
        if1.I_CPU_A  = ~v.a;
        if1.I_CPU_D  = ~v.d;
        if1.I_CPU_WE = ~v.we;
        if1.I_MEM_Q  = v.mq;
        n = 0;
        done = 1'b0;
        while (!done && n < 8) begin
            @(posedge clk); #1;
            n++;
            chk("we_one_cycle", 32'(if1.O_MEM_WE), 32'd0);
            if (if1.O_CPU_ACK) begin
                done = 1'b1;
                chk("cpu_ack_latency", 32'(n), 32'd1);
                chk("wait_at_ack", 32'(if1.O_CPU_WAIT), 32'd0);
                e = sb.pop_front();
                if (e.rd) chk("cpu_rd_q", 32'(if1.O_CPU_Q), 32'(e.q));
                if1.I_CPU_REQ = 1'b0;
            end
        end
        if (!done) begin
            fail_timeout("cpu_ack_timeout");
            void'(sb.pop_front());
            if1.I_CPU_REQ = 1'b0;
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin : main
        exp_t        e;
        int          acks;
        int          cyc;
        int          last_cyc;
        int          n;
        bit          done;
        logic [23:0] mq_edge;

        //          we    a         d      dam   mq          exp_we  exp_q
        vecs[0]  = '{1'b1, 16'h8005, 8'h5A, 1'b0, 24'h000000, 3'b010, 8'h00};
        vecs[1]  = '{1'b1, 16'h4010, 8'h3C, 1'b1, 24'h000000, 3'b110, 8'h00};
        vecs[2]  = '{1'b1, 16'h0010, 8'h3C, 1'b1, 24'h000000, 3'b111, 8'h00};
        vecs[3]  = '{1'b1, 16'h0011, 8'hA1, 1'b0, 24'h000000, 3'b000, 8'h00};
        vecs[4]  = '{1'b1, 16'h4001, 8'h01, 1'b0, 24'h000000, 3'b001, 8'h00};
        vecs[5]  = '{1'b1, 16'hC002, 8'h02, 1'b0, 24'h000000, 3'b100, 8'h00};
        vecs[6]  = '{1'b1, 16'h8003, 8'h03, 1'b1, 24'h000000, 3'b101, 8'h00};
        vecs[7]  = '{1'b1, 16'hC004, 8'h04, 1'b1, 24'h000000, 3'b011, 8'h00};
        vecs[8]  = '{1'b0, 16'hC020, 8'h00, 1'b0, 24'h112233, 3'b000, 8'h11};
        vecs[9]  = '{1'b0, 16'h0021, 8'h00, 1'b0, 24'h112233, 3'b000, 8'hFF};
        vecs[10] = '{1'b0, 16'h4022, 8'h00, 1'b0, 24'h112233, 3'b000, 8'h33};
        vecs[11] = '{1'b0, 16'h8023, 8'h00, 1'b0, 24'h445566, 3'b000, 8'h55};
        vecs[12] = '{1'b0, 16'h8024, 8'h00, 1'b1, 24'h778899, 3'b000, 8'h88};

        rst1 = 1'b1;
        rst3 = 1'b1;
        if1.I_CPU_REQ = 1'b0; if1.I_CPU_WE = 1'b0; if1.I_CPU_A = '0; if1.I_CPU_D = '0;
        if1.I_DAM = 1'b0; if1.I_DSP_REQ = 1'b0; if1.I_DSP_A = '0; if1.I_MEM_Q = '0;
        if3.I_CPU_REQ = 1'b0; if3.I_CPU_WE = 1'b0; if3.I_CPU_A = '0; if3.I_CPU_D = '0;
        if3.I_DAM = 1'b0; if3.I_DSP_REQ = 1'b0; if3.I_DSP_A = '0; if3.I_MEM_Q = '0;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        rst3 = 1'b0;
        @(posedge clk); #1;

        // Reset / idle values.
        chk("rst_mem_a",   32'(if1.O_MEM_A),   32'd0);
        chk("rst_mem_we",  32'(if1.O_MEM_WE),  32'd0);
        chk("rst_mem_d",   32'(if1.O_MEM_D),   32'd0);
        chk("rst_cpu_q",   32'(if1.O_CPU_Q),   32'hFF);
        chk("rst_dsp_q",   32'(if1.O_DSP_Q),   32'd0);
        chk("rst_cpu_ack", 32'(if1.O_CPU_ACK), 32'd0);
        chk("rst_dsp_ack", 32'(if1.O_DSP_ACK), 32'd0);
        chk("rst_wait",    32'(if1.O_CPU_WAIT), 32'd0);

        // Single display fetch.
        if1.I_DSP_REQ = 1'b1;
        if1.I_DSP_A   = 14'h0123;
        if1.I_MEM_Q   = 24'hAABBCC;
        @(posedge clk); #1;
        chk("dsp_grant_addr", 32'(if1.O_MEM_A),   32'h0123);
        chk("dsp_grant_we",   32'(if1.O_MEM_WE),  32'd0);
        chk("dsp_grant_ack",  32'(if1.O_DSP_ACK), 32'd0);
        if1.I_DSP_A = 14'h3FFF;
        @(posedge clk); #1;
        chk("dsp_ack",      32'(if1.O_DSP_ACK), 32'd1);
        chk("dsp_q",        32'(if1.O_DSP_Q),   32'hAABBCC);
        chk("dsp_addr_held", 32'(if1.O_MEM_A),  32'h0123);
        if1.I_DSP_REQ = 1'b0;
        @(posedge clk); #1;
        chk("dsp_ack_pulse", 32'(if1.O_DSP_ACK), 32'd0);

        // CPU access vectors.
        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Both requesters held high: grants alternate starting with display.
        if1.I_CPU_REQ = 1'b1; if1.I_CPU_WE = 1'b0; if1.I_CPU_A = 16'h4007; if1.I_DAM = 1'b0;
        if1.I_DSP_REQ = 1'b1; if1.I_DSP_A = 14'h0100;
        if1.I_MEM_Q   = 24'($urandom);
        for (int k = 0; k < 8; k++) begin
            e.is_cpu = (k % 2) == 1;
            e.rd     = 1'b1;
            e.q      = 8'h00;
            sb.push_back(e);
        end
        acks = 0; cyc = 0; last_cyc = 0;
        while (acks < 8 && cyc < 40) begin
            mq_edge = if1.I_MEM_Q;
            @(posedge clk); #1;
            cyc++;
            if (if1.O_DSP_ACK && if1.O_CPU_ACK) begin
                chk("alt_dual_ack", 32'd1, 32'd0);
            end else if (if1.O_DSP_ACK || if1.O_CPU_ACK) begin
                e = sb.pop_front();
                chk("alt_order", 32'(if1.O_CPU_ACK), 32'(e.is_cpu));
                if (e.is_cpu) chk("alt_cpu_q", 32'(if1.O_CPU_Q), 32'(mq_edge[7:0]));
                else          chk("alt_dsp_q", 32'(if1.O_DSP_Q), 32'(mq_edge));
                if (acks > 0) chk("alt_spacing", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                acks++;
                if (acks == 8) begin
                    if1.I_CPU_REQ = 1'b0;
                    if1.I_DSP_REQ = 1'b0;
                end
            end
            if1.I_MEM_Q = 24'($urandom);
        end
        if (acks < 8) begin
            fail_timeout("alt_timeout");
            if1.I_CPU_REQ = 1'b0;
            if1.I_DSP_REQ = 1'b0;
            sb.delete();
        end
        @(posedge clk); #1;
        chk("alt_quiet_cpu", 32'(if1.O_CPU_ACK), 32'd0);
        chk("alt_quiet_dsp", 32'(if1.O_DSP_ACK), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // MEM_LAT=3: reset right after grant aborts the write.
        if3.I_CPU_REQ = 1'b1; if3.I_CPU_WE = 1'b1; if3.I_CPU_A = 16'hC033;
        if3.I_CPU_D = 8'h77; if3.I_DAM = 1'b0;
        @(posedge clk); #1;
        chk("l3_grant_we",   32'(if3.O_MEM_WE), 32'b100);
        chk("l3_grant_addr", 32'(if3.O_MEM_A),  32'h0033);
        chk("l3_grant_data", 32'(if3.O_MEM_D),  32'h77);
        #2 rst3 = 1'b1;
        #1;
        chk("l3_rst_we",   32'(if3.O_MEM_WE),  32'd0);
        chk("l3_rst_ack",  32'(if3.O_CPU_ACK), 32'd0);
        chk("l3_rst_addr", 32'(if3.O_MEM_A),   32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("l3_rst_no_ack", 32'(if3.O_CPU_ACK), 32'd0);
        end
        rst3 = 1'b0;   // requester still holds REQ: re-issue
        @(posedge clk); #1;
        chk("l3_reissue_we",   32'(if3.O_MEM_WE),   32'b100);
        chk("l3_reissue_addr", 32'(if3.O_MEM_A),    32'h0033);
        chk("l3_reissue_wait", 32'(if3.O_CPU_WAIT), 32'd1);
        if3.I_DAM = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 10) begin
            @(posedge clk); #1;
            n++;
            chk("l3_we_one_cycle", 32'(if3.O_MEM_WE), 32'd0);
            if (if3.O_CPU_ACK) begin
                done = 1'b1;
                chk("l3_wr_latency", 32'(n), 32'd3);
                if3.I_CPU_REQ = 1'b0;
            end else begin
                chk("l3_wait_high", 32'(if3.O_CPU_WAIT), 32'd1);
            end
        end
        if (!done) begin
            fail_timeout("l3_wr_timeout");
            if3.I_CPU_REQ = 1'b0;
        end

        // MEM_LAT=3 read: data must be captured at the ACK edge, not earlier.
        if3.I_CPU_REQ = 1'b1; if3.I_CPU_WE = 1'b0; if3.I_CPU_A = 16'h8001; if3.I_DAM = 1'b0;
        @(posedge clk); #1;
        chk("l3_rd_addr", 32'(if3.O_MEM_A), 32'h0001);
        if3.I_MEM_Q = 24'($urandom);
        n = 0; done = 1'b0;
        while (!done && n < 10) begin
            mq_edge = if3.I_MEM_Q;
            @(posedge clk); #1;
            n++;
            if (if3.O_CPU_ACK) begin
                done = 1'b1;
                chk("l3_rd_latency", 32'(n), 32'd3);
                chk("l3_rd_q", 32'(if3.O_CPU_Q), 32'(mq_edge[15:8]));
                if3.I_CPU_REQ = 1'b0;
            end
            if3.I_MEM_Q = 24'($urandom);
        end
        if (!done) begin
            fail_timeout("l3_rd_timeout");
            if3.I_CPU_REQ = 1'b0;
        end
        @(posedge clk); #1;
        chk("l3_ack_pulse", 32'(if3.O_CPU_ACK), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
